// File: rtl/wide_add_pkg.sv
// Shared definitions for the byte-serial wide adder: byte width, default
// operand size and the sequencer state encoding.
package wide_add_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq. The master side offers
// operands and consumes results; the slave side is the sequencer.
interface wide_add_seq_if
    import wide_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
);
    localparam int W = NBYTES * BYTE_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, op_a, op_b, op_sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

endinterface

// File: rtl/byte_add8.sv
// Combinational 8-bit carry-chain slice. Besides the sum and carry-out it
// exposes the carry into bit 7 so the caller can form signed overflow.
module byte_add8
    import wide_add_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    output logic              c7
);

    logic [7:0] low_s;

    // Add the low seven bits separately so the carry into bit 7 is visible,
    // then finish the top bit by hand.
    always_comb begin
        low_s = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
        c7    = low_s[7];
        sum   = {a[7] ^ b[7] ^ low_s[7], low_s[6:0]};
        cout  = (a[7] & b[7]) | (low_s[7] & (a[7] ^ b[7]));
    end

endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial wide add/subtract sequencer. A single byte_add8 slice is
// reused LSB-first, one byte per clock; operands and result move over
// valid/ready handshakes carried by wide_add_seq_if.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF,
    parameter int IDXW   = $clog2(NBYTES)
)(
    input  logic           clk,
    input  logic           rst_n,
    wide_add_seq_if.slave  bus
);

    localparam logic [IDXW-1:0] IDX_ZERO = IDXW'(0);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

    state_t                         state_r;
    state_t                         state_nx_s;
    logic [NBYTES-1:0][BYTE_W-1:0]  a_r;
    logic [NBYTES-1:0][BYTE_W-1:0]  b_r;
    logic [NBYTES-1:0][BYTE_W-1:0]  result_r;
    logic [IDXW-1:0]                idx_r;
    logic                           carry_r;
    logic                           cout_r;
    logic                           ovf_r;
    logic                           in_ready_r;
    logic                           out_valid_r;

    logic                           accept_s;
    logic                           last_s;
    logic [BYTE_W-1:0]              sum_s;
    logic                           slice_cout_s;
    logic                           slice_c7_s;

    byte_add8 u_slice (
        .a    (a_r[idx_r]),
        .b    (b_r[idx_r]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (slice_cout_s),
        .c7   (slice_c7_s)
    );

    // Next-state logic: accept in IDLE, walk the bytes in RUN, wait for the
    // consumer in DONE.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        last_s     = (idx_r == IDX_LAST);
        case (state_r)
            IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = RUN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, per-byte result write-back, flags and registered
    // handshake outputs (derived from the next state so they line up with it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '{default: 8'd0};
            b_r         <= '{default: 8'd0};
            result_r    <= '{default: 8'd0};
            idx_r       <= IDX_ZERO;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                a_r     <= bus.op_a;
                // Subtraction is A + ~B + 1: invert B here, inject the +1 as
                // the initial carry.
                b_r     <= bus.op_sub ? ~bus.op_b : bus.op_b;
                carry_r <= bus.op_sub;
                idx_r   <= IDX_ZERO;
            end else if (state_r == RUN) begin
                result_r[idx_r] <= sum_s;
                carry_r         <= slice_cout_s;
                if (last_s) begin
                    idx_r  <= IDX_ZERO;
                    cout_r <= slice_cout_s;
                    ovf_r  <= slice_c7_s ^ slice_cout_s;
                end else begin
                    idx_r  <= idx_r + IDX_ONE;
                end
            end else begin
                idx_r <= idx_r;
            end
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;

endmodule
